// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sap_pkg
// Description : Shared types and sizing constants for the SAP program loader
//               and the 16x8 program RAM it fills.
//               Contents:
//                 loader_state_t - loader FSM state encoding
//                 SAP_DATA_W     - RAM word / stream byte width
//                 SAP_ADDR_W     - RAM address width
//                 SAP_DEPTH      - words per program image
// Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

  localparam int SAP_DATA_W = 8;
  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } loader_state_t;

endpackage : sap_pkg
`default_nettype wire

// File: rtl/sap_program_loader_if.sv
`default_nettype none
// ============================================================================
// Interface   : sap_program_loader_if
// Description : Byte-stream handshake into the loader plus the RAM write port
//               driven by the loader.
//               Signals:
//                 in_valid  - stream byte present
//                 in_data   - stream byte
//                 in_ready  - loader accepts in_data this cycle
//                 mem_we    - RAM write enable
//                 mem_addr  - RAM write address
//                 mem_wdata - RAM write data
//               Modports:
//                 slave  - loader side (consumes stream, drives RAM port)
//                 master - stream source / RAM side
// Revision    : 1.0 - initial release
// ============================================================================
interface sap_program_loader_if
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface : sap_program_loader_if
`default_nettype wire

// File: rtl/sap_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : sap_program_loader
// Description : Loads a DEPTH-word program image from a valid/ready byte
//               stream into the SAP program RAM (addresses 0..DEPTH-1),
//               then checks one trailing checksum byte (mod 2**DATA_W sum of
//               the image). Holds the CPU in reset for the whole load.
//               Ports:
//                 clock    - system clock, rising edge
//                 reset    - asynchronous active-low reset
//                 start    - single-cycle load request (ignored while busy)
//                 abort    - cancels a load in progress
//                 bus      - stream in / RAM write port (slave modport)
//                 cpu_hold - registered, ORed into the CPU reset
//                 busy     - registered, high in LOAD/CSUM/DONE
//                 done     - one-cycle pulse at end of a completed load
//                 csum_ok  - checksum result of the last completed load
// Revision    : 1.0 - initial release
// ============================================================================
module sap_program_loader
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int DEPTH  = SAP_DEPTH
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic             abort,
  sap_program_loader_if.slave   bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  csum_ok
);

  if (DEPTH != (2 ** ADDR_W)) begin : g_depth_check
    $error("sap_program_loader: DEPTH must equal 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     state;
  loader_state_t     state_next;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sum;
  logic              ready;
  logic              we;
  logic              start_ok;

  // start is only honoured from IDLE, and abort overrides it there.
  assign start_ok = (state == IDLE) && start && !abort;

  // --------------------------------------------------------------------------
  // Next-state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    we         = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_next = LOAD;
      end
      LOAD: begin
        ready = 1'b1;
        // A byte accepted in the abort cycle is still written.
        we    = bus.in_valid;
        if (abort) begin
          state_next = IDLE;
        end else if (bus.in_valid && (addr == LAST_ADDR)) begin
          state_next = CSUM;
        end
      end
      CSUM: begin
        ready = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (bus.in_valid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = bus.in_data;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Address counter and checksum accumulator; addr wraps to 0 after the
  // last word, which lines it up for the next image.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr <= '0;
      sum  <= '0;
    end else if (start_ok) begin
      addr <= '0;
      sum  <= '0;
    end else if ((state == LOAD) && bus.in_valid) begin
      addr <= addr + 1'b1;
      sum  <= sum + bus.in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Status flags. cpu_hold is only released by a completed load, so an
  // aborted load leaves the CPU held while busy drops.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      csum_ok  <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);

      if (start_ok) begin
        cpu_hold <= 1'b1;
      end else if (state == DONE) begin
        cpu_hold <= 1'b0;
      end

      if (start_ok) begin
        csum_ok <= 1'b0;
      end else if (((state == LOAD) || (state == CSUM)) && abort) begin
        csum_ok <= 1'b0;
      end else if ((state == CSUM) && bus.in_valid) begin
        csum_ok <= (bus.in_data == sum);
      end
    end
  end

endmodule : sap_program_loader
`default_nettype wire
